// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Upstream stage of the per-row delay FIFO bank feeding the systolic array.
//   The block captures a DIM x DIM operand matrix one row at a time (LOAD).
//   It then streams the matrix column by column into DIM lanes (STREAM).
//   Finally it pushes FLUSH_CYCLES zero columns to flush the skew (FLUSH).
//
// Parameters
//   DIM          matrix dimension, which is also the number of lanes
//   BITS         element width
//   FLUSH_CYCLES number of zero columns pushed after the data (0 skips FLUSH)
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_valid/in_ready/in_row  row write path; element j at [j*BITS +: BITS]
//   hold         downstream stall; freezes STREAM/FLUSH
//   fifo_en      shared shift enable to all delay FIFOs
//   fifo_d       lane data; lane i at [i*BITS +: BITS]
//   busy         high in STREAM or FLUSH
//   done         one-cycle pulse after the final column has been issued
//   drop_cnt     saturating count of in_valid cycles seen while not ready.
//                This port is present only when FEEDER_STATUS_EN is defined.
module systolic_feeder #(
  parameter int unsigned DIM          = 4,
  parameter int unsigned BITS         = 8,
  parameter int unsigned FLUSH_CYCLES = 2*DIM-2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIM*BITS-1:0] in_row,
  input  logic                hold,
  output logic                fifo_en,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic                busy,
  output logic                done
`ifdef FEEDER_STATUS_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int unsigned RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [RW-1:0] LAST_IDX   = RW'(DIM - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_STREAM,
    ST_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [RW-1:0]     col_cnt_q, col_cnt_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              done_q, done_d;
  logic              accept;
  logic [DIM*BITS-1:0] mem_q [DIM];

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;
    fifo_en     = 1'b0;
    fifo_d      = '0;
    busy        = 1'b0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          if (row_cnt_q == LAST_IDX) begin
            row_cnt_d = '0;
            state_d   = ST_STREAM;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        busy = 1'b1;
        if (!hold) begin
          fifo_en = 1'b1;
          // Column col_cnt of the stored matrix: lane i takes row i, element col_cnt
          for (int unsigned i = 0; i < DIM; i++) begin
            fifo_d[i*BITS +: BITS] = mem_q[i][col_cnt_q*BITS +: BITS];
          end
          if (col_cnt_q == LAST_IDX) begin
            col_cnt_d = '0;
            if (FLUSH_CYCLES == 0) begin
              state_d = ST_LOAD;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FLUSH;
            end
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        busy = 1'b1;
        if (!hold) begin
          fifo_en = 1'b1;
          if (flush_cnt_q == LAST_FLUSH) begin
            flush_cnt_d = '0;
            state_d     = ST_LOAD;
            done_d      = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  // Matrix storage is deliberately left unreset; a fresh load overwrites every row.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem_q[row_cnt_q] <= in_row;
    end
  end

  assign done = done_q;

`ifdef FEEDER_STATUS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (in_valid && !in_ready && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int W    = DIM*BITS;
  localparam int FL   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, hold, in_ready, fifo_en, busy, done;
  logic [W-1:0] in_row, fifo_d;
  logic         b_in_valid, b_hold, b_in_ready, b_fifo_en, b_busy, b_done;
  logic [W-1:0] b_in_row, b_fifo_d;
`ifdef FEEDER_STATUS_EN
  logic [15:0]  drop_cnt, b_drop_cnt;
`endif

  systolic_feeder #(.DIM(DIM), .BITS(BITS), .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .hold(hold), .fifo_en(fifo_en), .fifo_d(fifo_d), .busy(busy), .done(done)
`ifdef FEEDER_STATUS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  systolic_feeder #(.DIM(DIM), .BITS(BITS), .FLUSH_CYCLES(0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .hold(b_hold), .fifo_en(b_fifo_en), .fifo_d(b_fifo_d), .busy(b_busy), .done(b_done)
`ifdef FEEDER_STATUS_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mat [DIM];
  logic [W-1:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(input int base);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mat[r][c*BITS +: BITS] = 8'(base + r*16 + c);
  endtask

  // Expected stream: transpose of mat, then nflush zero columns.
  task automatic push_matrix(input int nflush);
    logic [W-1:0] col;
    for (int c = 0; c < DIM; c++) begin
      col = '0;
      for (int i = 0; i < DIM; i++) col[i*BITS +: BITS] = mat[i][c*BITS +: BITS];
      exp_q.push_back(col);
    end
    repeat (nflush) exp_q.push_back('0);
  endtask

  task automatic load_a();
    for (int r = 0; r < DIM; r++) begin
      in_valid = 1'b1;
      in_row   = mat[r];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_row = '0;
    b_in_valid = 1'b0; b_hold = 1'b0; b_in_row = '0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({in_ready, fifo_en, busy, done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctl: got %b required 1000", {in_ready, fifo_en, busy, done});
    end
    n_checks++;
    if (fifo_d !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", fifo_d);
    end
    n_checks++;
    if ({b_in_ready, b_fifo_en, b_busy, b_done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctl_nf: got %b required 1000", {b_in_ready, b_fifo_en, b_busy, b_done});
    end
`ifdef FEEDER_STATUS_EN
    n_checks++;
    if (drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_cnt);
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [W-1:0] col;
    set_pattern(0);
    for (int c = 0; c < DIM; c++) begin
      for (int i = 0; i < DIM; i++) col[i*BITS +: BITS] = 8'(i*16 + c);
      exp_q.push_back(col);
    end
    repeat (FL) exp_q.push_back('0);
    load_a();
    for (int n = 0; n < DIM + FL; n++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo_en, busy, done, in_ready} !== 4'b1100) begin
        n_fail++; $display("FAIL stream_ctl[%0d]: got %b required 1100", n, {fifo_en, busy, done, in_ready});
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h required <nothing>", n, fifo_d);
      end else begin
        e = exp_q.pop_front();
        if (fifo_d !== e) begin
          n_fail++; $display("FAIL stream_data[%0d]: got %h required %h", n, fifo_d, e);
        end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({fifo_en, busy, done, in_ready, fifo_d} !== {4'b0011, 32'h0}) begin
      n_fail++; $display("FAIL stream_done: got %b/%h required 0011/0", {fifo_en, busy, done, in_ready}, fifo_d);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got %b required 0", done);
    end
    tick();
  endtask

  task automatic test_hold();
    set_pattern(0);
    push_matrix(FL);
    load_a();
    for (int n = 0; n < DIM + FL + 3; n++) begin
      hold = (n >= 2 && n < 5);
      @(negedge clk);
      n_checks++;
      if (hold) begin
        if ({fifo_en, busy, done, in_ready, fifo_d} !== {4'b0100, 32'h0}) begin
          n_fail++; $display("FAIL hold_stall[%0d]: got %b/%h required 0100/0", n, {fifo_en, busy, done, in_ready}, fifo_d);
        end
      end else if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL hold_data[%0d]: got %h required <nothing>", n, fifo_d);
      end else begin
        e = exp_q.pop_front();
        if ({fifo_en, busy, done, in_ready, fifo_d} !== {4'b1100, e}) begin
          n_fail++; $display("FAIL hold_data[%0d]: got %b/%h required 1100/%h", n, {fifo_en, busy, done, in_ready}, fifo_d, e);
        end
      end
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({fifo_en, busy, done, in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL hold_done: got %b required 0011", {fifo_en, busy, done, in_ready});
    end
    tick();
  endtask

  task automatic test_reset_abort();
    set_pattern(100);
    push_matrix(FL);
    load_a();
    for (int n = 0; n < 2; n++) begin
      if (n == 1) rst = 1'b1;
      @(negedge clk);
      n_checks++;
      e = exp_q.pop_front();
      if ({fifo_en, fifo_d} !== {1'b1, e}) begin
        n_fail++; $display("FAIL abort_pre[%0d]: got %b/%h required 1/%h", n, fifo_en, fifo_d, e);
      end
      tick();
    end
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo_en, busy, done, in_ready, fifo_d} !== {4'b0001, 32'h0}) begin
        n_fail++; $display("FAIL abort_idle[%0d]: got %b/%h required 0001/0", n, {fifo_en, busy, done, in_ready}, fifo_d);
      end
      tick();
    end
    set_pattern(200);
    push_matrix(FL);
    load_a();
    for (int n = 0; n < DIM + FL; n++) begin
      @(negedge clk);
      n_checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if ({fifo_en, busy, fifo_d} !== {2'b11, e}) begin
        n_fail++; $display("FAIL abort_reload[%0d]: got %b/%h required 11/%h", n, {fifo_en, busy}, fifo_d, e);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({fifo_en, busy, done, in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL abort_done: got %b required 0011", {fifo_en, busy, done, in_ready});
    end
    tick();
  endtask

  task automatic test_continuous();
    int p;
    logic exp_en, exp_done, exp_ready;
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 28; t++) begin
      in_row = {8'(t*4 + 35), 8'(t*4 + 34), 8'(t*4 + 33), 8'(t*4 + 32)};
      p = t % 14;
      exp_ready = (p < DIM);
      exp_en    = (p >= DIM);
      exp_done  = (p == 0) && (t > 0);
      if (exp_ready) begin
        mat[p] = in_row;
        if (p == DIM - 1) push_matrix(FL);
      end
      @(negedge clk);
      n_checks++;
      if ({fifo_en, busy, done, in_ready} !== {exp_en, exp_en, exp_done, exp_ready}) begin
        n_fail++; $display("FAIL cont_ctl[%0d]: got %b required %b", t, {fifo_en, busy, done, in_ready},
                           {exp_en, exp_en, exp_done, exp_ready});
      end
      if (exp_en) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (fifo_d !== e) begin
          n_fail++; $display("FAIL cont_data[%0d]: got %h required %h", t, fifo_d, e);
        end
      end
`ifdef FEEDER_STATUS_EN
      if (t == 14) begin
        n_checks++;
        if (drop_cnt !== 16'd10) begin
          n_fail++; $display("FAIL cont_drop1: got %0d required 10", drop_cnt);
        end
      end
`endif
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({fifo_en, busy, done, in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL cont_done2: got %b required 0011", {fifo_en, busy, done, in_ready});
    end
`ifdef FEEDER_STATUS_EN
    n_checks++;
    if (drop_cnt !== 16'd20) begin
      n_fail++; $display("FAIL cont_drop2: got %0d required 20", drop_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_no_flush();
    set_pattern(50);
    push_matrix(0);
    for (int r = 0; r < DIM; r++) begin
      b_in_valid = 1'b1;
      b_in_row   = mat[r];
      tick();
    end
    b_in_valid = 1'b0;
    for (int n = 0; n < DIM; n++) begin
      @(negedge clk);
      n_checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if ({b_fifo_en, b_busy, b_done, b_in_ready, b_fifo_d} !== {4'b1100, e}) begin
        n_fail++; $display("FAIL nf_data[%0d]: got %b/%h required 1100/%h", n, {b_fifo_en, b_busy, b_done, b_in_ready}, b_fifo_d, e);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({b_fifo_en, b_busy, b_done, b_in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL nf_done: got %b required 0011", {b_fifo_en, b_busy, b_done, b_in_ready});
    end
    tick();
  endtask

  task automatic test_drop_saturate();
`ifdef FEEDER_STATUS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    set_pattern(0);
    hold = 1'b1;
    load_a();
    in_valid = 1'b1;
    repeat (65534) tick();
    @(negedge clk);
    n_checks++;
    if ({fifo_en, drop_cnt} !== {1'b0, 16'hFFFE}) begin
      n_fail++; $display("FAIL drop_near: got %b/%h required 0/fffe", fifo_en, drop_cnt);
    end
    repeat (6) tick();
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL drop_sat: got %h required ffff", drop_cnt);
    end
    in_valid = 1'b0; hold = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_reset_abort();
    test_continuous();
    test_no_flush();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
